muldiv_issue_ctrl: RTL

Sequencing and writeback controller for the out-of-order core's multiply/divide execution path. It accepts M-extension ops from the mul/div reservation station and routes each one to one of two shared sequential units: the multiplier (funct3[2]=0) or the divider (funct3[2]=1). It pulses each unit's start, holds the operands stable until done, and buffers one result per unit. It arbitrates the two result buffers onto a single CDB port with round-robin priority and backpressure. A branch-mispredict flush abandons in-flight work without letting stale completions escape.

---
 rtl/muldiv_issue_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_issue_ctrl.sv
// Multiply/divide issue and writeback controller: steers M-extension ops to the shared
// sequential multiplier or divider, buffers one result per unit and arbitrates them onto the CDB.

module muldiv_unit_fsm #(
    parameter int TAG_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 accept,
    input  logic                 grant,
    input  logic                 done,
    input  logic [2:0]           in_op,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    input  logic [31:0]          result,
    output logic                 ready,
    output logic                 start,
    output logic                 req,
    output logic [2:0]           op,
    output logic [TAG_WIDTH-1:0] tag,
    output logic [31:0]          a,
    output logic [31:0]          b,
    output logic [31:0]          data
);

    typedef enum logic [2:0] {IDLE, START, BUSY, HOLD, DRAIN} state_t;

    state_t state;

    assign ready = (state == IDLE) & ~rst & ~flush;
    assign req   = (state == HOLD);

    // DRAIN swallows the done of an op abandoned by flush so it can never reach the CDB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            start <= 1'b0;
            op    <= '0;
            tag   <= '0;
            a     <= '0;
            b     <= '0;
            data  <= '0;
        end else if (flush) begin
            start <= 1'b0;
            case (state)
                START, BUSY: state <= done ? IDLE : DRAIN;
                HOLD:        state <= IDLE;
                DRAIN:       if (done) state <= IDLE;
                default:     state <= state;
            endcase
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= START;
                        start <= 1'b1;
                        op    <= in_op;
                        tag   <= in_tag;
                        a     <= in_a;
                        b     <= in_b;
                    end
                end
                START, BUSY: begin
                    if (done) begin
                        data  <= result;
                        state <= HOLD;
                    end else begin
                        state <= BUSY;
                    end
                end
                HOLD:    if (grant) state <= IDLE;
                DRAIN:   if (done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

module muldiv_issue_ctrl #(
    parameter int TAG_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [2:0]           issue_funct3,
    input  logic [TAG_WIDTH-1:0] issue_tag,
    input  logic [31:0]          issue_rs1,
    input  logic [31:0]          issue_rs2,
    output logic                 mul_ready,
    output logic                 div_ready,
    input  logic                 flush,
    output logic                 mul_start,
    output logic [2:0]           mul_op,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic                 mul_done,
    input  logic [31:0]          mul_result,
    output logic                 div_start,
    output logic [2:0]           div_op,
    output logic [31:0]          div_a,
    output logic [31:0]          div_b,
    input  logic                 div_done,
    input  logic [31:0]          div_result,
    output logic                 cdb_valid,
    output logic [TAG_WIDTH-1:0] cdb_tag,
    output logic [31:0]          cdb_data,
    input  logic                 cdb_stall
);

    logic                 mul_accept, div_accept;
    logic                 mul_req, div_req;
    logic                 mul_grant, div_grant;
    logic                 sel_div;
    logic                 rr;
    logic [TAG_WIDTH-1:0] mul_tag, div_tag;
    logic [31:0]          mul_data, div_data;

    assign mul_accept = issue_valid & ~flush & ~issue_funct3[2] & mul_ready;
    assign div_accept = issue_valid & ~flush &  issue_funct3[2] & div_ready;

    // rr = 0 favours the multiplier, 1 the divider, when both are holding results.
    assign sel_div   = div_req & (~mul_req | rr);
    assign cdb_valid = (mul_req | div_req) & ~flush;
    assign cdb_tag   = sel_div ? div_tag  : mul_tag;
    assign cdb_data  = sel_div ? div_data : mul_data;
    assign mul_grant = cdb_valid & ~cdb_stall & ~sel_div;
    assign div_grant = cdb_valid & ~cdb_stall &  sel_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (mul_grant | div_grant) begin
            rr <= ~sel_div;
        end
    end

    muldiv_unit_fsm #(.TAG_WIDTH(TAG_WIDTH)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .accept (mul_accept),
        .grant  (mul_grant),
        .done   (mul_done),
        .in_op  (issue_funct3),
        .in_tag (issue_tag),
        .in_a   (issue_rs1),
        .in_b   (issue_rs2),
        .result (mul_result),
        .ready  (mul_ready),
        .start  (mul_start),
        .req    (mul_req),
        .op     (mul_op),
        .tag    (mul_tag),
        .a      (mul_a),
        .b      (mul_b),
        .data   (mul_data)
    );

    muldiv_unit_fsm #(.TAG_WIDTH(TAG_WIDTH)) u_div (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .accept (div_accept),
        .grant  (div_grant),
        .done   (div_done),
        .in_op  (issue_funct3),
        .in_tag (issue_tag),
        .in_a   (issue_rs1),
        .in_b   (issue_rs2),
        .result (div_result),
        .ready  (div_ready),
        .start  (div_start),
        .req    (div_req),
        .op     (div_op),
        .tag    (div_tag),
        .a      (div_a),
        .b      (div_b),
        .data   (div_data)
    );

endmodule
